// File: rtl/t_7458_bist_ctrl.sv
// BIST sequencer for the t_7458 dual AND-OR block: sweeps all 1024 input vectors and checks p1y/p2y against a golden model.
// Optional build macro T7458_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module t_7458_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       p1_o,
  output logic [3:0]       p2_o,
  input  logic             p1y_i,
  input  logic             p2y_i,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int                 CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX     = '1;
  localparam logic [9:0]         VEC_LAST    = 10'd1023;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [9:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic             mismatch;
  logic             sweep_end;
  logic [ERR_W-1:0] err_nxt;

  // Expected {p2y, p1y} for a vector laid out as {p2d..p2a, p1f..p1a}.
  function automatic logic [1:0] golden(input logic [9:0] v);
    logic [1:0] y;
    y[0] = (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]);
    y[1] = (v[6] & v[7]) | (v[8] & v[9]);
    return y;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == ERR_MAX) ? c : c + 1'b1;
  endfunction

  assign mismatch = ({p2y_i, p1y_i} != golden(vec));
  assign err_nxt  = sat_inc(err_cnt);

`ifdef T7458_BIST_STOP_ON_FAIL_EN
  assign sweep_end = mismatch || (vec == VEC_LAST);
`else
  assign sweep_end = (vec == VEC_LAST);
`endif

  // vec is a register, so the gate-block drive is glitch-free.
  assign p1_o = vec[5:0];
  assign p2_o = vec[9:6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SETTLE;
            vec              <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_nxt;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (sweep_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err_cnt has not yet absorbed this vector's result
            pass  <= !mismatch && (err_cnt == '0);
          end else begin
            vec   <= vec + 1'b1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t_7458_bist_ctrl.sv
// Directed bench for t_7458_bist_ctrl: behavioural gate block with injectable stuck-at faults,
// plus a second instance with a narrow error counter to reach saturation.
module tb_t_7458_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  int          fault;

  logic        busy, done, pass, p1y, p2y, ffvalid;
  logic [5:0]  p1_o;
  logic [3:0]  p2_o;
  logic [10:0] err_cnt;
  logic [9:0]  ffvec;

  logic        s_busy, s_done, s_pass, s_p1y, s_p2y, s_ffvalid;
  logic [5:0]  s_p1_o;
  logic [3:0]  s_p2_o;
  logic [8:0]  s_err_cnt;
  logic [9:0]  s_ffvec;

  int errors = 0;
  int checks = 0;
  int cyc;

`ifdef T7458_BIST_STOP_ON_FAIL_EN
  localparam int E2_CYC = 579;  localparam int E2_ERR = 1;   localparam int E2_P1 = 0;  localparam int E2_P2 = 3;
  localparam int E3_CYC = 3;    localparam int E3_ERR = 1;   localparam int E3_SAT = 1;
`else
  localparam int E2_CYC = 3072; localparam int E2_ERR = 448; localparam int E2_P1 = 63; localparam int E2_P2 = 15;
  localparam int E3_CYC = 3072; localparam int E3_ERR = 784; localparam int E3_SAT = 511;
`endif

  always #5 clk = ~clk;

  // Gate block under test; mode 1: p2y stuck-at-0, mode 2: p1y stuck-at-1.
  function automatic logic [1:0] gate(input logic [5:0] a, input logic [3:0] b, input int mode);
    logic [1:0] y;
    y[0] = (a[0] & a[1] & a[2]) | (a[3] & a[4] & a[5]);
    y[1] = (b[0] & b[1]) | (b[2] & b[3]);
    if (mode == 1) y[1] = 1'b0;
    if (mode == 2) y[0] = 1'b1;
    return y;
  endfunction

  always_comb {p2y, p1y}     = gate(p1_o, p2_o, fault);
  always_comb {s_p2y, s_p1y} = gate(s_p1_o, s_p2_o, fault);

  t_7458_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .p1_o(p1_o), .p2_o(p2_o), .p1y_i(p1y), .p2y_i(p2y), .err_cnt(err_cnt),
    .first_fail_vec(ffvec), .first_fail_valid(ffvalid)
  );

  t_7458_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(9)) dut_s (
    .clk(clk), .rst(rst), .start(start), .busy(s_busy), .done(s_done), .pass(s_pass),
    .p1_o(s_p1_o), .p2_o(s_p2_o), .p1y_i(s_p1y), .p2y_i(s_p2y), .err_cnt(s_err_cnt),
    .first_fail_vec(s_ffvec), .first_fail_valid(s_ffvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then count cycles until done (bounded); optional extra start mid-sweep.
  task automatic sweep(input int extra_at, output int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    n = 0;
    while (!done && n < 4000) begin
      if (n == extra_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ffvalid", ffvalid, 0);
    chk("rst_p1", p1_o, 0);
    chk("rst_p2", p2_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // clean gate block
    fault = 0;
    sweep(-1, cyc);
    chk("t1_cycles", cyc, 3072);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_ffvalid", ffvalid, 0);
    chk("t1_p1", p1_o, 63);
    chk("t1_p2", p2_o, 15);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_done_held", done, 1);
    chk("t1_p1_held", p1_o, 63);

    // p2y stuck-at-0
    fault = 1;
    sweep(-1, cyc);
    chk("t2_cycles", cyc, E2_CYC);
    chk("t2_err", err_cnt, E2_ERR);
    chk("t2_ffvec", ffvec, 192);
    chk("t2_ffvalid", ffvalid, 1);
    chk("t2_pass", pass, 0);
    chk("t2_p1", p1_o, E2_P1);
    chk("t2_p2", p2_o, E2_P2);
    chk("t2_sat_err", s_err_cnt, E2_ERR);

    // p1y stuck-at-1; narrow counter saturates
    fault = 2;
    sweep(-1, cyc);
    chk("t3_cycles", cyc, E3_CYC);
    chk("t3_err", err_cnt, E3_ERR);
    chk("t3_ffvec", ffvec, 0);
    chk("t3_ffvalid", ffvalid, 1);
    chk("t3_pass", pass, 0);
    chk("t3_sat_err", s_err_cnt, E3_SAT);
    chk("t3_sat_pass", s_pass, 0);

    // async reset mid-sweep
    fault = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("t4_busy_pre", busy, 1);
    chk("t4_p1_pre", p1_o, 33);
    rst = 1'b1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_p1", p1_o, 0);
    chk("t4_p2", p2_o, 0);
    chk("t4_err", err_cnt, 0);
    chk("t4_ffvalid", ffvalid, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    sweep(-1, cyc);
    chk("t4_cycles", cyc, 3072);
    chk("t4_pass", pass, 1);

    // start while busy is ignored
    fault = 1;
    sweep(500, cyc);
    chk("t5_cycles", cyc, E2_CYC);
    chk("t5_err", err_cnt, E2_ERR);
    chk("t5_ffvec", ffvec, 192);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
